ring_pos_from_remote_dispatcher: RTL and testbench
==================================================

Name: ring_pos_from_remote_dispatcher

Overview:
- Receive-side counterpart of the remote position TX arbiter.
- Accepts the single position-flit stream arriving from remote FPGA nodes and routes each data flit to one of the local position rings through a small per-ring FIFO.
- Tracks per-source end-of-iteration markers and signals the iteration complete once every remote source has finished and all ring FIFOs have drained.

Parameters:
- NUM_REMOTE_SRC_NODES, 8, number of remote nodes sending positions to this node.
- SRC_IDX_WIDTH, 3, width of the source node index; equals clog2(NUM_REMOTE_SRC_NODES).
- NUM_LOCAL_RINGS, 4, number of local position rings.
- RING_IDX_WIDTH, 2, width of the ring index; equals clog2(NUM_LOCAL_RINGS).
- POS_DATA_WIDTH, 96, position payload width.
- FIFO_DEPTH, 4, entries per ring FIFO; must be a power of 2.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- i_iter_start  in  1  one-cycle pulse that opens a receive iteration.
- i_pkt_valid  in  1  incoming flit valid.
- i_pkt_data  in  POS_DATA_WIDTH  position payload.
- i_pkt_src  in  SRC_IDX_WIDTH  sending remote node index.
- i_pkt_ring  in  RING_IDX_WIDTH  destination local ring.
- i_pkt_last  in  1  flit is a marker-only end-of-iteration flit; its data and ring fields are ignored.
- o_pkt_ready  out  1  flit accepted this cycle when valid and ready are both high.
- o_ring_valid  out  NUM_LOCAL_RINGS  per-ring output valid.
- o_ring_data  out  NUM_LOCAL_RINGS*POS_DATA_WIDTH  ring r occupies bits [r*W +: W].
- i_ring_ready  in  NUM_LOCAL_RINGS  per-ring consumer ready.
- o_src_done  out  NUM_REMOTE_SRC_NODES  marker received from source s during this iteration.
- o_iter_done  out  1  one-cycle pulse marking iteration complete.
- o_busy  out  1  state is not IDLE.
- o_pkt_count  out  16  data flits enqueued this iteration; saturates at 0xFFFF.
- o_err  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset: state IDLE; all FIFOs empty; o_ring_valid=0, o_src_done=0, o_pkt_count=0; o_iter_done, o_err, o_busy, o_pkt_ready all 0. Reset overrides any in-flight flit.
- State IDLE:
  - o_pkt_ready=0.
  - i_iter_start moves the state to RECV next cycle and clears o_src_done and o_pkt_count.
- State RECV, ready rule:
  - o_pkt_ready = i_pkt_last | !full[i_pkt_ring].
  - This is a combinational function of the input fields, so the sender must hold all fields stable while i_pkt_valid is high.
- State RECV, data flit accepted with o_src_done[src]=0:
  - Pushed into FIFO[i_pkt_ring].
  - o_pkt_count increments by 1, saturating.
- State RECV, data flit accepted with o_src_done[src]=1:
  - Dropped; o_err pulses.
- State RECV, marker flit accepted:
  - Sets o_src_done[src].
  - If that bit was already set, o_err pulses and nothing else changes.
- RECV exit: when every o_src_done bit is 1, the state moves to DRAIN on the next cycle. The marker-accept cycle counts, so the transition is visible one cycle after the final marker.
- State DRAIN:
  - o_pkt_ready=0.
  - When all FIFOs are empty, o_iter_done pulses for one cycle and the state returns to IDLE in that same cycle.
  - If all FIFOs are already empty on DRAIN entry, o_iter_done pulses on the first DRAIN cycle.
- i_iter_start in RECV or DRAIN: ignored; o_err pulses.
- FIFO behaviour:
  - First-word-fall-through; o_ring_valid[r] = !empty[r].
  - Pop on o_ring_valid & i_ring_ready.
  - Latency from accept to o_ring_valid is 1 cycle.
  - Simultaneous push and pop on a non-full FIFO keeps the occupancy unchanged.
  - When a FIFO is full, data flits to it are refused even if the same cycle pops it; there is no bypass.
  - Pointers wrap modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer bit.
- Ring independence: rings drain independently, so a stalled ring blocks only flits addressed to it.
- o_busy = (state != IDLE).

Test Plan:
- Reset, then iter_start, then one data flit src=2 ring=1 data=0xABC, with i_ring_ready=1 -> o_ring_valid=4'b0010 one cycle after accept, data 0xABC, o_pkt_count=1.
- i_ring_ready[0]=0, five flits to ring 0 -> first 4 accepted, 5th sees o_pkt_ready=0; raising ready pops in order and the 5th is accepted after the first pop.
- Markers from all 8 sources, FIFOs empty -> o_src_done=8'hFF, state DRAIN next cycle, o_iter_done pulses once on the first DRAIN cycle, then o_busy=0.
- Marker from src 3, then a data flit from src 3 -> flit dropped, o_err pulses, o_pkt_count unchanged; a duplicate marker from src 3 also pulses o_err.
- All markers received with 2 entries still in ring 2 -> o_iter_done is withheld until both entries pop, then pulses exactly once.
- Flit presented in IDLE -> o_pkt_ready=0; i_iter_start during RECV -> o_err=1 and o_src_done is not cleared; rst mid-RECV -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/ring_pos_from_remote_dispatcher.sv
// ring_pos_from_remote_dispatcher: routes remote position flits into per-ring FWFT FIFOs
// and reports iteration completion once every source has sent its marker and all rings drain.
module ring_pos_from_remote_dispatcher #(
    parameter int NUM_REMOTE_SRC_NODES = 8,
    parameter int SRC_IDX_WIDTH        = 3,
    parameter int NUM_LOCAL_RINGS      = 4,
    parameter int RING_IDX_WIDTH       = 2,
    parameter int POS_DATA_WIDTH       = 96,
    parameter int FIFO_DEPTH           = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      i_iter_start,
    input  logic                                      i_pkt_valid,
    input  logic [POS_DATA_WIDTH-1:0]                 i_pkt_data,
    input  logic [SRC_IDX_WIDTH-1:0]                  i_pkt_src,
    input  logic [RING_IDX_WIDTH-1:0]                 i_pkt_ring,
    input  logic                                      i_pkt_last,
    output logic                                      o_pkt_ready,
    output logic [NUM_LOCAL_RINGS-1:0]                o_ring_valid,
    output logic [NUM_LOCAL_RINGS*POS_DATA_WIDTH-1:0] o_ring_data,
    input  logic [NUM_LOCAL_RINGS-1:0]                i_ring_ready,
    output logic [NUM_REMOTE_SRC_NODES-1:0]           o_src_done,
    output logic                                      o_iter_done,
    output logic                                      o_busy,
    output logic [15:0]                               o_pkt_count,
    output logic                                      o_err
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;
    state_t state;

    logic [NUM_LOCAL_RINGS-1:0]      full, empty, push, pop;
    logic [NUM_REMOTE_SRC_NODES-1:0] src_bit, done_next;
    logic                            accept, seen, data_ok, err_next;

    assign src_bit     = NUM_REMOTE_SRC_NODES'(1) << i_pkt_src;
    assign o_pkt_ready = (state == RECV) && (i_pkt_last || !full[i_pkt_ring]);
    assign accept      = i_pkt_valid && o_pkt_ready;
    assign seen        = |(o_src_done & src_bit);
    assign data_ok     = accept && !i_pkt_last && !seen;
    // a flit from an already-finished source is a violation whether marker or data
    assign err_next    = (accept && seen) || (i_iter_start && state != IDLE);
    assign done_next   = o_src_done | ((accept && i_pkt_last) ? src_bit : '0);
    assign o_iter_done = (state == DRAIN) && (&empty);
    assign o_busy      = state != IDLE;
    assign o_ring_valid = ~empty;
    assign pop          = o_ring_valid & i_ring_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            o_src_done  <= '0;
            o_pkt_count <= '0;
            o_err       <= 1'b0;
        end else begin
            o_err <= err_next;
            if (state == IDLE && i_iter_start) begin
                state       <= RECV;
                o_src_done  <= '0;
                o_pkt_count <= '0;
            end else if (state == RECV) begin
                o_src_done <= done_next;
                if (data_ok && o_pkt_count != 16'hFFFF)
                    o_pkt_count <= o_pkt_count + 16'd1;
                if (&done_next)
                    state <= DRAIN;
            end else if (state == DRAIN && (&empty)) begin
                state <= IDLE;
            end
        end
    end

    for (genvar g = 0; g < NUM_LOCAL_RINGS; g++) begin : g_ring
        logic [POS_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [AW:0]               wr, rd;

        // extra pointer bit separates full from empty when the low bits match
        assign empty[g] = wr == rd;
        assign full[g]  = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
        assign push[g]  = data_ok && (i_pkt_ring == RING_IDX_WIDTH'(g));
        assign o_ring_data[g*POS_DATA_WIDTH +: POS_DATA_WIDTH] = mem[rd[AW-1:0]];

        always_ff @(posedge clk) begin
            if (rst) begin
                wr <= '0;
                rd <= '0;
            end else begin
                if (push[g]) begin
                    mem[wr[AW-1:0]] <= i_pkt_data;
                    wr              <= wr + 1'b1;
                end
                if (pop[g])
                    rd <= rd + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ring_pos_from_remote_dispatcher.sv
// tb_ring_pos_from_remote_dispatcher: directed vectors with hand-computed expectations.
module tb_ring_pos_from_remote_dispatcher;
    localparam int W = 96;

    logic          clk = 1'b0;
    logic          rst, iter_start, pkt_valid, pkt_last, pkt_ready;
    logic [W-1:0]  pkt_data;
    logic [2:0]    pkt_src;
    logic [1:0]    pkt_ring;
    logic [3:0]    ring_valid, ring_ready;
    logic [4*W-1:0] ring_data;
    logic [7:0]    src_done;
    logic          iter_done, busy, err;
    logic [15:0]   pkt_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ring_pos_from_remote_dispatcher dut (
        .clk(clk), .rst(rst), .i_iter_start(iter_start), .i_pkt_valid(pkt_valid),
        .i_pkt_data(pkt_data), .i_pkt_src(pkt_src), .i_pkt_ring(pkt_ring),
        .i_pkt_last(pkt_last), .o_pkt_ready(pkt_ready), .o_ring_valid(ring_valid),
        .o_ring_data(ring_data), .i_ring_ready(ring_ready), .o_src_done(src_done),
        .o_iter_done(iter_done), .o_busy(busy), .o_pkt_count(pkt_count), .o_err(err)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] src, input logic [1:0] ring, input logic [W-1:0] data,
                        input logic last);
        pkt_valid = 1'b1;
        pkt_src   = src;
        pkt_ring  = ring;
        pkt_data  = data;
        pkt_last  = last;
        tick;
        pkt_valid = 1'b0;
        pkt_last  = 1'b0;
    endtask

    function automatic logic [W-1:0] rdata(input int r);
        return ring_data[r*W +: W];
    endfunction

    initial begin
        rst = 1'b1; iter_start = 1'b0; pkt_valid = 1'b0; pkt_last = 1'b0;
        pkt_data = '0; pkt_src = '0; pkt_ring = '0; ring_ready = 4'hF;
        tick; tick;
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_ring_valid", ring_valid, 0);
        chk("rst_src_done", src_done, 0);
        chk("rst_count", pkt_count, 0);
        chk("rst_iter_done", iter_done, 0);
        chk("rst_err", err, 0);

        pkt_valid = 1'b1; pkt_data = 96'h5;
        #1 chk("idle_ready", pkt_ready, 0);
        pkt_valid = 1'b0;

        // single flit into ring 1
        iter_start = 1'b1; tick; iter_start = 1'b0;
        chk("recv_busy", busy, 1);
        pkt_valid = 1'b1; pkt_src = 3'd2; pkt_ring = 2'd1; pkt_data = 96'hABC;
        #1 chk("t1_ready", pkt_ready, 1);
        tick; pkt_valid = 1'b0;
        chk("t1_valid", ring_valid, 4'b0010);
        chk("t1_data", rdata(1), 96'hABC);
        chk("t1_count", pkt_count, 1);
        tick;
        chk("t1_popped", ring_valid, 0);

        // fill stalled ring 0, fifth flit must wait for a pop
        ring_ready = 4'b1110;
        for (int k = 0; k < 4; k++) send(3'd0, 2'd0, W'(100 + k), 1'b0);
        chk("t2_count4", pkt_count, 5);
        chk("t2_head", rdata(0), 100);
        pkt_ring = 2'd1;
        #1 chk("t2_other_ring_ready", pkt_ready, 1);
        pkt_valid = 1'b1; pkt_ring = 2'd0; pkt_data = 96'd104;
        #1 chk("t2_full_ready", pkt_ready, 0);
        ring_ready = 4'b1111;
        tick;
        chk("t2_pop1", rdata(0), 101);
        chk("t2_ready_after_pop", pkt_ready, 1);
        tick; pkt_valid = 1'b0;
        chk("t2_pop2", rdata(0), 102);
        tick; chk("t2_pop3", rdata(0), 103);
        tick; chk("t2_pop4", rdata(0), 104);
        tick; chk("t2_empty", ring_valid, 0);
        chk("t2_count6", pkt_count, 6);

        // protocol violations from source 3
        send(3'd3, 2'd0, '0, 1'b1);
        chk("t4_done3", src_done, 8'h08);
        chk("t4_no_err", err, 0);
        send(3'd3, 2'd2, 96'h77, 1'b0);
        chk("t4_drop_err", err, 1);
        chk("t4_drop_count", pkt_count, 6);
        chk("t4_drop_valid", ring_valid, 0);
        tick;
        chk("t4_err_pulse", err, 0);
        send(3'd3, 2'd0, '0, 1'b1);
        chk("t4_dup_err", err, 1);
        iter_start = 1'b1; tick; iter_start = 1'b0;
        chk("t6_start_err", err, 1);
        chk("t6_src_kept", src_done, 8'h08);
        chk("t6_busy", busy, 1);

        // drain withheld while ring 2 holds two entries
        ring_ready = 4'b1011;
        send(3'd0, 2'd2, 96'd200, 1'b0);
        send(3'd0, 2'd2, 96'd201, 1'b0);
        chk("t5_count", pkt_count, 8);
        for (int s = 0; s < 8; s++) if (s != 3) send(3'(s), 2'd0, '0, 1'b1);
        chk("t5_all_done", src_done, 8'hFF);
        chk("t5_drain_ready", pkt_ready, 0);
        chk("t5_withheld", iter_done, 0);
        tick;
        chk("t5_withheld2", iter_done, 0);
        ring_ready = 4'b1111;
        tick;
        chk("t5_one_left", iter_done, 0);
        chk("t5_data", rdata(2), 201);
        tick;
        chk("t5_iter_done", iter_done, 1);
        chk("t5_busy_drain", busy, 1);
        tick;
        chk("t5_pulse_end", iter_done, 0);
        chk("t5_idle", busy, 0);

        // all markers with empty rings: done on the first drain cycle
        iter_start = 1'b1; tick; iter_start = 1'b0;
        chk("t3_cleared", src_done, 0);
        chk("t3_count_clr", pkt_count, 0);
        for (int s = 0; s < 7; s++) send(3'(s), 2'd0, '0, 1'b1);
        chk("t3_not_yet", busy, 1);
        send(3'd7, 2'd0, '0, 1'b1);
        chk("t3_src_ff", src_done, 8'hFF);
        chk("t3_iter_done", iter_done, 1);
        tick;
        chk("t3_pulse_end", iter_done, 0);
        chk("t3_idle", busy, 0);

        // reset in the middle of an iteration
        iter_start = 1'b1; tick; iter_start = 1'b0;
        ring_ready = 4'b0000;
        send(3'd5, 2'd0, 96'h1234, 1'b0);
        send(3'd1, 2'd0, '0, 1'b1);
        chk("t6_pre_valid", ring_valid, 4'b0001);
        chk("t6_pre_done", src_done, 8'h02);
        rst = 1'b1; tick; rst = 1'b0;
        chk("t6_rst_valid", ring_valid, 0);
        chk("t6_rst_done", src_done, 0);
        chk("t6_rst_count", pkt_count, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_err", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
